// File: rtl/conv_scan_scheduler.sv
// Scan scheduler for the clause convolution datapath: walks the image in
// P-row bands, feeds column slices to the PE array and ORs windowed clause outputs.
module conv_scan_scheduler #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int PIPE_LAT = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] cfg_patch,
    input  logic [5:0] cfg_x_lo,
    input  logic [5:0] cfg_x_hi,
    input  logic [5:0] cfg_y_lo,
    input  logic [5:0] cfg_y_hi,
    output logic       img_rd_en,
    output logic [5:0] img_rd_row,
    output logic [5:0] img_rd_col,
    input  logic [6:0] img_rd_data,
    output logic [6:0] pixels,
    output logic [2:0] patch_size,
    output logic       pe_enable,
    output logic       conv_enable,
    output logic       Xmatch,
    output logic       Ymatch,
    input  logic       clause_op,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       clause_result
);

    // state   | meaning
    // S_IDLE  | waiting for start; cfg latched and accumulator cleared on start
    // S_SCAN  | issuing band/column reads, then two tail cycles for the read pipe
    // S_DRAIN | zeros on pixels while the last windows leave the datapath
    // S_DONE  | one-cycle done pulse, result and err valid
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [5:0] COL_LAST  = 6'(IMG_W - 1);
    localparam logic [6:0] IMG_H7    = 7'(IMG_H);
    localparam logic [7:0] DRAIN_CNT = 8'(PIPE_LAT);

    state_t                state_q, state_d;
    logic                  reading_q, reading_d;
    logic [5:0]            band_q, band_d;
    logic [5:0]            col_q, col_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            patch_q, patch_d;
    logic [5:0]            xlo_q, xlo_d, xhi_q, xhi_d, ylo_q, ylo_d, yhi_q, yhi_d;
    logic                  v1_q, v1_d, tag1_q, tag1_d, xm1_q, xm1_d, ym1_q, ym1_d;
    logic [6:0]            pixels_q, pixels_d;
    logic                  tag_q, tag_d, xm_q, xm_d, ym_q, ym_d;
    logic                  pe_q, pe_d;
    logic [PIPE_LAT-1:0]   tag_dly_q, tag_dly_d;
    logic                  acc_q, acc_d, res_q, res_d, err_q, err_d;

    logic       patch_ok;
    logic       rd_en;
    logic       col_is_win;
    logic [5:0] win_off;
    logic [5:0] x_pos;
    logic [6:0] band_last;
    logic [6:0] mask;

    always_comb begin
        patch_ok   = (cfg_patch == 3'd3) || (cfg_patch == 3'd5) || (cfg_patch == 3'd7);
        rd_en      = (state_q == S_SCAN) && reading_q;
        win_off    = {3'd0, patch_q} - 6'd1;
        col_is_win = col_q >= win_off;
        x_pos      = col_q - win_off;
        band_last  = IMG_H7 - {4'd0, patch_q};
        case (patch_q)
            3'd3:    mask = 7'h07;
            3'd5:    mask = 7'h1F;
            3'd7:    mask = 7'h7F;
            default: mask = 7'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        reading_d = reading_q;
        band_d    = band_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        patch_d   = patch_q;
        xlo_d     = xlo_q;
        xhi_d     = xhi_q;
        ylo_d     = ylo_q;
        yhi_d     = yhi_q;
        acc_d     = acc_q;
        res_d     = res_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    patch_d = cfg_patch;
                    xlo_d   = cfg_x_lo;
                    xhi_d   = cfg_x_hi;
                    ylo_d   = cfg_y_lo;
                    yhi_d   = cfg_y_hi;
                    acc_d   = 1'b0;
                    res_d   = 1'b0;
                    band_d  = 6'd0;
                    col_d   = 6'd0;
                    if (patch_ok) begin
                        state_d   = S_SCAN;
                        reading_d = 1'b1;
                        err_d     = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (reading_q) begin
                    if (col_q == COL_LAST) begin
                        col_d = 6'd0;
                        if ({1'b0, band_q} == band_last) begin
                            reading_d = 1'b0;
                            cnt_d     = 8'd1;
                        end else begin
                            band_d = band_q + 6'd1;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end else if (cnt_q == 8'd0) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_CNT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                    res_d   = acc_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // only windows whose delayed tag lines up with clause_op may set the result
        if (state_q == S_SCAN || state_q == S_DRAIN)
            acc_d = acc_q | (clause_op & tag_dly_q[PIPE_LAT-1]);
    end

    always_comb begin
        v1_d     = rd_en;
        tag1_d   = rd_en && col_is_win;
        xm1_d    = tag1_d && (x_pos >= xlo_q) && (x_pos <= xhi_q);
        ym1_d    = tag1_d && (band_q >= ylo_q) && (band_q <= yhi_q);
        pixels_d = v1_q ? (img_rd_data & mask) : 7'd0;
        tag_d    = tag1_q;
        xm_d     = xm1_q;
        ym_d     = ym1_q;
        pe_d     = (pe_q || v1_q) && (state_d == S_SCAN || state_d == S_DRAIN);
        tag_dly_d    = tag_dly_q;
        tag_dly_d[0] = tag_q;
        for (int i = 1; i < PIPE_LAT; i++)
            tag_dly_d[i] = tag_dly_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            reading_q <= 1'b0;
            band_q    <= 6'd0;
            col_q     <= 6'd0;
            cnt_q     <= 8'd0;
            patch_q   <= 3'd0;
            xlo_q     <= 6'd0;
            xhi_q     <= 6'd0;
            ylo_q     <= 6'd0;
            yhi_q     <= 6'd0;
            v1_q      <= 1'b0;
            tag1_q    <= 1'b0;
            xm1_q     <= 1'b0;
            ym1_q     <= 1'b0;
            pixels_q  <= 7'd0;
            tag_q     <= 1'b0;
            xm_q      <= 1'b0;
            ym_q      <= 1'b0;
            pe_q      <= 1'b0;
            tag_dly_q <= '0;
            acc_q     <= 1'b0;
            res_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            reading_q <= reading_d;
            band_q    <= band_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            patch_q   <= patch_d;
            xlo_q     <= xlo_d;
            xhi_q     <= xhi_d;
            ylo_q     <= ylo_d;
            yhi_q     <= yhi_d;
            v1_q      <= v1_d;
            tag1_q    <= tag1_d;
            xm1_q     <= xm1_d;
            ym1_q     <= ym1_d;
            pixels_q  <= pixels_d;
            tag_q     <= tag_d;
            xm_q      <= xm_d;
            ym_q      <= ym_d;
            pe_q      <= pe_d;
            tag_dly_q <= tag_dly_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            err_q     <= err_d;
        end
    end

    assign img_rd_en     = rd_en;
    assign img_rd_row    = rd_en ? band_q : 6'd0;
    assign img_rd_col    = rd_en ? col_q : 6'd0;
    assign pixels        = pixels_q;
    assign patch_size    = patch_q;
    assign pe_enable     = pe_q;
    assign conv_enable   = pe_q;
    assign Xmatch        = xm_q;
    assign Ymatch        = ym_q;
    assign busy          = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign clause_result = res_q;

endmodule

// File: tb/tb_conv_scan_scheduler.sv
// Directed bench for conv_scan_scheduler on an 8x8 image with a behavioural
// image memory and a cycle-indexed clause_op stub.
module tb_conv_scan_scheduler;

    localparam int PL = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] cfg_patch;
    logic [5:0] cfg_x_lo, cfg_x_hi, cfg_y_lo, cfg_y_hi;
    logic       img_rd_en;
    logic [5:0] img_rd_row, img_rd_col;
    logic [6:0] img_rd_data;
    logic [6:0] pixels;
    logic [2:0] patch_size;
    logic       pe_enable, conv_enable, Xmatch, Ymatch;
    logic       clause_op;
    logic       busy, done, err, clause_result;

    logic [63:0] img_bits;
    logic [30:0] out_vec;

    int n_checks = 0;
    int n_errors = 0;

    int s_reads, s_both, s_xm, s_ym, s_seq_err, s_pix_err, s_ctl_err, s_done_cyc;
    logic s_res, s_err;
    logic [2:0] s_patch;

    conv_scan_scheduler #(.IMG_W(8), .IMG_H(8), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_patch(cfg_patch),
        .cfg_x_lo(cfg_x_lo), .cfg_x_hi(cfg_x_hi), .cfg_y_lo(cfg_y_lo), .cfg_y_hi(cfg_y_hi),
        .img_rd_en(img_rd_en), .img_rd_row(img_rd_row), .img_rd_col(img_rd_col),
        .img_rd_data(img_rd_data), .pixels(pixels), .patch_size(patch_size),
        .pe_enable(pe_enable), .conv_enable(conv_enable), .Xmatch(Xmatch), .Ymatch(Ymatch),
        .clause_op(clause_op), .busy(busy), .done(done), .err(err), .clause_result(clause_result)
    );

    always #5 clk = ~clk;

    assign out_vec = {img_rd_en, img_rd_row, img_rd_col, pixels, patch_size, pe_enable,
                      conv_enable, Xmatch, Ymatch, busy, done, err, clause_result};

    // rows past the image bottom read back as 1 so masking is visible
    function automatic logic [6:0] col_slice(input int r, input int c);
        logic [6:0] s;
        for (int i = 0; i < 7; i++)
            s[i] = (r + i < 8) ? img_bits[(r + i) * 8 + c] : 1'b1;
        return s;
    endfunction

    function automatic logic [6:0] mask_of(input logic [2:0] p);
        return (p == 3'd3) ? 7'h07 : (p == 3'd5) ? 7'h1F : (p == 3'd7) ? 7'h7F : 7'h00;
    endfunction

    always @(posedge clk)
        img_rd_data <= img_rd_en ? col_slice(int'(img_rd_row), int'(img_rd_col)) : 7'($urandom);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: clause_op low; 1: pulse for window (x=2,y=1); 2: high on every untagged delayed cycle
    task automatic run_scan(input logic [2:0] p, input logic [5:0] xl, input logic [5:0] xh,
                            input logic [5:0] yl, input logic [5:0] yh, input int mode,
                            input int restart_at);
        int nr, last_busy, k;
        logic tg, exp_pe;
        logic [6:0] exp_pix;
        nr        = (p == 3'd3 || p == 3'd5 || p == 3'd7) ? (9 - int'(p)) * 8 : 0;
        last_busy = (nr > 0) ? nr + PL + 3 : 0;
        s_reads = 0; s_both = 0; s_xm = 0; s_ym = 0;
        s_seq_err = 0; s_pix_err = 0; s_ctl_err = 0; s_done_cyc = -1;
        s_res = 1'bx; s_err = 1'bx; s_patch = 3'bx;
        cfg_patch = p; cfg_x_lo = xl; cfg_x_hi = xh; cfg_y_lo = yl; cfg_y_hi = yh;
        start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 300; n++) begin
            k  = n - 3 - PL;
            tg = (k >= 0) && (k < nr) && ((k % 8) >= int'(p) - 1);
            case (mode)
                1:       clause_op = (k >= 0) && (k < nr) && (k / 8 == 1) && (k % 8 == int'(p) + 1);
                2:       clause_op = !tg;
                default: clause_op = 1'b0;
            endcase
            if (n == restart_at) begin
                start     = 1'b1;
                cfg_patch = 3'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (img_rd_en) begin
                if (img_rd_row != 6'(s_reads / 8) || img_rd_col != 6'(s_reads % 8))
                    s_seq_err++;
                s_reads++;
            end
            k       = n - 3;
            exp_pix = (k >= 0 && k < nr) ? (col_slice(k / 8, k % 8) & mask_of(p)) : 7'd0;
            if (pixels != exp_pix) s_pix_err++;
            exp_pe = (n >= 3) && (n <= last_busy);
            if (pe_enable != exp_pe || conv_enable != exp_pe || busy != (n <= last_busy))
                s_ctl_err++;
            if (Xmatch && Ymatch) s_both++;
            if (Xmatch) s_xm++;
            if (Ymatch) s_ym++;
            if (done) begin
                s_done_cyc = n;
                s_res      = clause_result;
                s_err      = err;
                s_patch    = patch_size;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        clause_op = 1'b0;
        @(negedge clk);
        if (done) s_ctl_err++;
        @(posedge clk); #1;
    endtask

    task automatic verify(input string tag, input int reads, input int both, input int xm,
                          input int ym, input int done_cyc, input logic res, input logic er,
                          input logic [2:0] p);
        check({tag, "_reads"}, s_reads, reads);
        check({tag, "_rdseq"}, s_seq_err, 0);
        check({tag, "_pixels"}, s_pix_err, 0);
        check({tag, "_ctl"}, s_ctl_err, 0);
        check({tag, "_tagged"}, s_both, both);
        check({tag, "_xmatch"}, s_xm, xm);
        check({tag, "_ymatch"}, s_ym, ym);
        check({tag, "_done_cyc"}, s_done_cyc, done_cyc);
        check({tag, "_result"}, {31'd0, s_res}, {31'd0, res});
        check({tag, "_err"}, {31'd0, s_err}, {31'd0, er});
        check({tag, "_patch"}, {29'd0, s_patch}, {29'd0, p});
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; clause_op = 1'b0;
        cfg_patch = 3'd0; cfg_x_lo = 6'd0; cfg_x_hi = 6'd0; cfg_y_lo = 6'd0; cfg_y_hi = 6'd0;
        img_bits = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {1'b0, out_vec}, 32'd0);
        @(posedge clk); #1;

        // all-zero image, P=3: 6 bands x 8 reads, 6x6 windows
        run_scan(3'd3, 6'd0, 6'd63, 6'd0, 6'd63, 0, 0);
        verify("p3_zero", 48, 36, 36, 36, 48 + PL + 4, 1'b0, 1'b0, 3'd3);

        img_bits = {$urandom, $urandom};
        run_scan(3'd5, 6'd2, 6'd2, 6'd1, 6'd1, 1, 0);
        verify("p5_hit", 32, 1, 4, 4, 32 + PL + 4, 1'b1, 1'b0, 3'd5);

        run_scan(3'd7, 6'd0, 6'd63, 6'd0, 6'd63, 2, 0);
        verify("p7_untagged", 16, 4, 4, 4, 16 + PL + 4, 1'b0, 1'b0, 3'd7);

        run_scan(3'd4, 6'd0, 6'd63, 6'd0, 6'd63, 2, 0);
        verify("illegal", 0, 0, 0, 0, 1, 1'b0, 1'b1, 3'd4);

        run_scan(3'd3, 6'd0, 6'd63, 6'd0, 6'd63, 0, 10);
        verify("restart", 48, 36, 36, 36, 48 + PL + 4, 1'b0, 1'b0, 3'd3);

        // abort during read 20 (band 2, column 4)
        cfg_patch = 3'd3; cfg_x_lo = 6'd0; cfg_x_hi = 6'd63; cfg_y_lo = 6'd0; cfg_y_hi = 6'd63;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        check("rd20_row", {26'd0, img_rd_row}, 32'd2);
        check("rd20_col", {26'd0, img_rd_col}, 32'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {1'b0, out_vec}, 32'd0);
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("abort_no_done", dones, 0);
        @(posedge clk); #1;

        run_scan(3'd5, 6'd2, 6'd2, 6'd1, 6'd1, 1, 0);
        verify("after_abort", 32, 1, 4, 4, 32 + PL + 4, 1'b1, 1'b0, 3'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_scan_scheduler.md
CONV_SCAN_SCHEDULER -- requirements
Module: conv_scan_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels (8..64).
REQ-002 SHALL have parameter IMG_H, default 28, image height in pixels (8..64).
REQ-003 SHALL have parameter PIPE_LAT, default 6, cycles from a column on pixels to its clause_op.
REQ-004 SHALL have port clk  in  1  clock, rising-edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a scan.
REQ-007 SHALL have port cfg_patch  in  3  patch size; legal values are 3, 5 and 7.
REQ-008 SHALL have ports cfg_x_lo, cfg_x_hi, cfg_y_lo, cfg_y_hi  in  6 each  clause position window, inclusive.
REQ-009 SHALL have ports img_rd_en out 1, img_rd_row out 6, img_rd_col out 6  image read request (band top row, column).
REQ-010 SHALL have port img_rd_data  in  7  column slice returned one cycle after img_rd_en; bit i is row img_rd_row+i.
REQ-011 SHALL have ports pixels out 7, patch_size out 3, pe_enable out 1, conv_enable out 1, Xmatch out 1, Ymatch out 1  convolution datapath drive.
REQ-012 SHALL have port clause_op  in  1  datapath clause output.
REQ-013 SHALL have ports busy out 1, done out 1, err out 1, clause_result out 1  status.

Function
REQ-014 SHALL implement states IDLE, SCAN, DRAIN, DONE; transitions IDLE->SCAN on start with legal cfg, SCAN->DRAIN after last column read, DRAIN->DONE after PIPE_LAT+1 cycles, DONE->IDLE after one cycle.
REQ-015 SHALL latch all cfg_* inputs on accepted start; patch_size output SHALL equal the latched value until the next start.
REQ-016 SHALL ignore start while busy; busy SHALL be 1 in SCAN and DRAIN.
REQ-017 SHALL, on start with illegal cfg_patch (not 3/5/7), go directly to DONE with err=1 and clause_result=0 on the next cycle.
REQ-018 SHALL, in SCAN, issue one read per cycle: band b = 0..IMG_H-P outer, col c = 0..IMG_W-1 inner; img_rd_row=b, img_rd_col=c.
REQ-019 SHALL register img_rd_data onto pixels, masking bits i >= P to 0; pixels SHALL be 0 outside SCAN data cycles.
REQ-020 SHALL assert pe_enable and conv_enable from the first pixels cycle through the end of DRAIN, and hold both at 0 otherwise.
REQ-021 SHALL feed 0 on pixels during DRAIN.
REQ-022 SHALL tag a pixels cycle as window-valid when its column c >= P-1; window x = c-(P-1), window y = b.
REQ-023 SHALL drive Xmatch=(cfg_x_lo<=x<=cfg_x_hi) and Ymatch=(cfg_y_lo<=y<=cfg_y_hi) in the same cycle as the tagged pixels, and drive both to 0 on untagged cycles.
REQ-024 SHALL delay the valid tag by PIPE_LAT cycles and OR clause_op into an accumulator only on cycles when the delayed tag is 1.
REQ-025 SHALL clear the accumulator on an accepted start.
REQ-026 SHALL restart the valid tag at column 0 of every band, so no window spans two bands.
REQ-027 SHALL pulse done for exactly one cycle in DONE and SHALL update clause_result and err in that same cycle; clause_result and err SHALL hold until the next accepted start.
REQ-028 SHALL count exactly (IMG_H-P+1)*IMG_W reads per scan and (IMG_H-P+1)*(IMG_W-P+1) tagged cycles per scan.

Reset
REQ-029 SHALL, on rst, enter IDLE and drive every output to 0, including patch_size, clause_result and err.
REQ-030 SHALL, on rst asserted mid-scan, abort without a done pulse and discard accumulated state.

Verification
REQ-031 SHALL cover: IMG 8x8, P=3, all-zero image, stub clause_op=0 -> 48 reads, 36 tagged cycles, done with clause_result=0 and err=0.
REQ-032 SHALL cover: P=5, stub raises clause_op once PIPE_LAT cycles after the tagged cycle for window (x=2, y=1), x/y range covering it -> clause_result=1.
REQ-033 SHALL cover: clause_op=1 only on untagged delayed cycles (band start columns and DRAIN) -> clause_result=0.
REQ-034 SHALL cover: cfg_patch=4 -> done one cycle after start, err=1, no img_rd_en asserted.
REQ-035 SHALL cover: start repeated mid-SCAN -> ignored, and the read sequence is unchanged.
REQ-036 SHALL cover: rst at read 20 of a scan -> all outputs 0 on the next cycle, no done pulse, and a fresh start completes normally.
